gcd_8_bit: RTL and testbench



---
 rtl/gcd_8_bit.sv | 110 +++++++++++
 tb/tb_gcd_8_bit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gcd_8_bit.sv
// Euclidean subtraction GCD engine with start/busy/done handshake; operands are
// compared by a comp_8_bit instance. Define GCD_ITER_COUNT_EN to add the iter_cnt output.

module comp_8_bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);
    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);
endmodule

module gcd_8_bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] gcd
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [7:0] iter_cnt
`endif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] a;
    logic [7:0] b;
    logic       gt;
    logic       eq;
    logic       lt;

    comp_8_bit u_comp (
        .a  (a),
        .b  (b),
        .gt (gt),
        .eq (eq),
        .lt (lt)
    );

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            gcd   <= '0;
`ifdef GCD_ITER_COUNT_EN
            iter_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a <= a_in;
                        b <= b_in;
`ifdef GCD_ITER_COUNT_EN
                        iter_cnt <= '0;
`endif
                        // A zero operand skips RUN; gcd(0,0) falls out as 0
                        if (a_in == 8'd0) begin
                            gcd   <= b_in;
                            state <= DONE;
                        end else if (b_in == 8'd0) begin
                            gcd   <= a_in;
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (eq) begin
                        gcd   <= a;
                        state <= DONE;
                    end else begin
                        if (gt) begin
                            a <= a - b;
                        end else if (lt) begin
                            b <= b - a;
                        end
`ifdef GCD_ITER_COUNT_EN
                        if (iter_cnt != 8'hFF) begin
                            iter_cnt <= iter_cnt + 8'd1;
                        end
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_8_bit.sv
// Self-checking bench for gcd_8_bit: directed and random jobs against a
// division-based Euclid reference model, plus a mid-job asynchronous reset.

module tb_gcd_8_bit;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] gcd;
`ifdef GCD_ITER_COUNT_EN
    logic [7:0] iter_cnt;
`endif

    int checks = 0;
    int errors = 0;

    gcd_8_bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .gcd   (gcd)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_cnt (iter_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // gcd via division remainders; subtraction count is the sum of quotients minus one
    function automatic void ref_gcd(input logic [7:0] x_in, input logic [7:0] y_in,
                                    output logic [7:0] g, output int k);
        int x;
        int y;
        int t;
        int q;
        x = x_in;
        y = y_in;
        if (x == 0) begin
            g = y_in;
            k = 0;
        end else if (y == 0) begin
            g = x_in;
            k = 0;
        end else begin
            q = 0;
            while (y != 0) begin
                q += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            g = 8'(x);
            k = q - 1;
            if (k > 255) k = 255;
        end
    endfunction

    task automatic run_job(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input bit inject);
        logic [7:0] exp_g;
        int         k;
        int         edges;
        bit         seen;
        bit         nonzero;
        ref_gcd(a, b, exp_g, k);
        nonzero = (a != 8'd0) && (b != 8'd0);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        seen  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            check({tag, "_busy_run"}, {7'd0, busy}, {7'd0, nonzero});
            if (inject) begin
                a_in  = 8'd7;
                b_in  = 8'd3;
                start = (c == 1);
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, {7'd0, seen}, 8'd1);
        check({tag, "_latency"}, 8'(edges), nonzero ? 8'(k + 1) : 8'd0);
        check({tag, "_busy_done"}, {7'd0, busy}, 8'd0);
        check({tag, "_gcd"}, gcd, exp_g);
`ifdef GCD_ITER_COUNT_EN
        check({tag, "_iter"}, iter_cnt, 8'(k));
`endif
        if (inject) begin
            a_in  = 8'd7;
            b_in  = 8'd3;
            start = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, {7'd0, done}, 8'd0);
        check({tag, "_busy_idle"}, {7'd0, busy}, 8'd0);
        check({tag, "_gcd_hold"}, gcd, exp_g);
`ifdef GCD_ITER_COUNT_EN
        check({tag, "_iter_hold"}, iter_cnt, 8'(k));
`endif
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        @(negedge clk);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_gcd", gcd, 8'd0);
`ifdef GCD_ITER_COUNT_EN
        check("rst_iter", iter_cnt, 8'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_job("j12_8", 8'd12, 8'd8, 1'b0);
        run_job("j255_1", 8'd255, 8'd1, 1'b0);
        run_job("j1_255", 8'd1, 8'd255, 1'b0);
        run_job("j0_9", 8'd0, 8'd9, 1'b0);
        run_job("j9_0", 8'd9, 8'd0, 1'b0);
        run_job("j0_0", 8'd0, 8'd0, 1'b0);
        run_job("j13_13", 8'd13, 8'd13, 1'b0);
        run_job("j200_150_inj", 8'd200, 8'd150, 1'b1);

        // Abort a long job with reset 100 edges after it was accepted
        @(negedge clk);
        a_in  = 8'd255;
        b_in  = 8'd1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {7'd0, busy}, 8'd0);
        check("async_rst_done", {7'd0, done}, 8'd0);
        check("async_rst_gcd", gcd, 8'd0);
`ifdef GCD_ITER_COUNT_EN
        check("async_rst_iter", iter_cnt, 8'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_job("j48_18", 8'd48, 8'd18, 1'b0);

        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom_range(1, 255));
            rb = 8'($urandom_range(1, 255));
            if (i % 8 == 7) ra = 8'd0;
            run_job("rand", ra, rb, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
